// File: rtl/iiq_pkg.sv
// iiq_pkg: shared types and constants for the integer issue queue scheduler.
//   iiq_entry_t : one issue-queue entry (source tags/ready bits, destination,
//                 FU latency code, opaque payload).
//   lat_cycles  : decodes the 2-bit latency field into a cycle count.
package iiq_pkg;

   localparam int IIQ_N_ENTRIES  = 4;
   localparam int PHYS_TAG_WIDTH = 6;
   localparam int MAX_LAT        = 4;
   localparam int PAYLOAD_WIDTH  = 8;

   typedef struct packed {
      logic                      src1_ready;
      logic [PHYS_TAG_WIDTH-1:0] src1_tag;
      logic                      src2_ready;
      logic [PHYS_TAG_WIDTH-1:0] src2_tag;
      logic                      dst_valid;
      logic [PHYS_TAG_WIDTH-1:0] dst_tag;
      logic [1:0]                lat;
      logic [PAYLOAD_WIDTH-1:0]  payload;
   } iiq_entry_t;

   // The 2-bit field holds 1..3 literally; code 0 stands for MAX_LAT (4),
   // since 4 does not fit in two bits and 0 is never a legal latency.
   function automatic logic [2:0] lat_cycles(input logic [1:0] lat_field);
      lat_cycles = (lat_field == 2'd0) ? 3'(MAX_LAT) : {1'b0, lat_field};
   endfunction

endpackage

// File: rtl/wake_delay_line.sv
// wake_delay_line: shift register of pending destination-tag broadcasts.
//   clk, rst_aL          : clock, synchronous active-low reset
//   ins_valid/lat/tag    : schedule a broadcast lat cycles from now
//   head_valid/head_tag  : slot 0, the broadcast happening this cycle
//   slot_busy            : per-slot valid bits, used for conflict queries
module wake_delay_line
   import iiq_pkg::*;
#(
   parameter int MAX_LAT   = iiq_pkg::MAX_LAT,
   parameter int TAG_WIDTH = PHYS_TAG_WIDTH,
   parameter int LW        = $clog2(MAX_LAT + 1)
) (
   input  logic                 clk,
   input  logic                 rst_aL,
   input  logic                 ins_valid,
   input  logic [LW-1:0]        ins_lat,
   input  logic [TAG_WIDTH-1:0] ins_tag,
   output logic                 head_valid,
   output logic [TAG_WIDTH-1:0] head_tag,
   output logic [MAX_LAT-1:0]   slot_busy
);

   logic [MAX_LAT-1:0]   valid_reg;
   logic [TAG_WIDTH-1:0] tag_reg [MAX_LAT];

   for (genvar gi = 0; gi < MAX_LAT; gi++) begin : g_slot
      // Insert lands at slot lat-1 so that, after the shift, it reaches
      // slot 0 exactly lat cycles after issue. The select stage already
      // guaranteed the shifted-in value here is invalid.
      always_ff @(posedge clk) begin
         if (!rst_aL) begin
            valid_reg[gi] <= 1'b0;
            tag_reg[gi]   <= '0;
         end else if (ins_valid && (ins_lat == LW'(gi + 1))) begin
            valid_reg[gi] <= 1'b1;
            tag_reg[gi]   <= ins_tag;
         end else begin
            if (gi < MAX_LAT - 1) begin
               valid_reg[gi] <= valid_reg[(gi + 1) % MAX_LAT];
               tag_reg[gi]   <= tag_reg[(gi + 1) % MAX_LAT];
            end else begin
               valid_reg[gi] <= 1'b0;
               tag_reg[gi]   <= '0;
            end
         end
      end
   end

   assign head_valid = valid_reg[0];
   assign head_tag   = tag_reg[0];
   assign slot_busy  = valid_reg;

endmodule

// File: rtl/iiq_scheduler.sv
// iiq_scheduler: wakeup/select controller for the integer issue shift queue.
//   ren_*           : rename-side handshake, forwarded to the queue enqueue port
//   q_enq_*         : queue enqueue, data merged with same-cycle wakeups
//   q_deq_*         : oldest-ready one-hot select and dequeued entry
//   q_wr_en/q_wr_data, q_entry_douts : per-entry ready-bit write-back
//   fu_ready, iss_* : issue to the integer FU
//   ext_wake_*      : external tag broadcasts; int_wake_* : our own broadcast
//   occupancy       : number of valid queue entries
module iiq_scheduler
   import iiq_pkg::*;
#(
   parameter int N_ENTRIES  = IIQ_N_ENTRIES,
   parameter int TAG_WIDTH  = PHYS_TAG_WIDTH,
   parameter int MAX_LAT    = iiq_pkg::MAX_LAT,
   parameter int N_EXT_WAKE = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_aL,
   input  logic                                 ren_valid,
   output logic                                 ren_ready,
   input  iiq_entry_t                           ren_entry,
   output logic                                 q_enq_valid,
   input  logic                                 q_enq_ready,
   output iiq_entry_t                           q_enq_data,
   output logic                                 q_deq_ready,
   output logic [N_ENTRIES-1:0]                 q_deq_sel_onehot,
   input  logic                                 q_deq_valid,
   input  iiq_entry_t                           q_deq_data,
   output logic [N_ENTRIES-1:0]                 q_wr_en,
   output iiq_entry_t [N_ENTRIES-1:0]           q_wr_data,
   input  iiq_entry_t [N_ENTRIES-1:0]           q_entry_douts,
   input  logic                                 fu_ready,
   output logic                                 iss_valid,
   output iiq_entry_t                           iss_entry,
   input  logic [N_EXT_WAKE-1:0]                ext_wake_valid,
   input  logic [N_EXT_WAKE-1:0][TAG_WIDTH-1:0] ext_wake_tag,
   output logic                                 int_wake_valid,
   output logic [TAG_WIDTH-1:0]                 int_wake_tag,
   output logic [$clog2(N_ENTRIES):0]           occupancy
);

   localparam int CW = $clog2(N_ENTRIES) + 1;
   localparam int NB = N_EXT_WAKE + 1;
   localparam int LW = $clog2(MAX_LAT + 1);

   logic [CW-1:0]                cnt_reg;
   logic                         s0_valid;
   logic [TAG_WIDTH-1:0]         s0_tag;
   logic [MAX_LAT-1:0]           slot_busy;
   logic [MAX_LAT:0]             busy_ext;
   logic [NB-1:0]                bc_valid;
   logic [NB-1:0][TAG_WIDTH-1:0] bc_tag;
   logic [N_ENTRIES-1:0]         cand;
   iiq_entry_t                   enq_merged;

   function automatic logic tag_hit(input logic [TAG_WIDTH-1:0] tag,
                                    input logic [NB-1:0] vld,
                                    input logic [NB-1:0][TAG_WIDTH-1:0] tags);
      tag_hit = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if (vld[b] && (tags[b] == tag)) tag_hit = 1'b1;
      end
   endfunction

   // The internal broadcast is just one more port of the broadcast set.
   assign bc_valid = {s0_valid, ext_wake_valid};
   assign bc_tag   = {s0_tag, ext_wake_tag};

   // Extra always-free top slot: a lat=MAX_LAT issue never conflicts.
   assign busy_ext = {1'b0, slot_busy};

   for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
      iiq_entry_t    e;
      iiq_entry_t    woke;
      logic          v, m1, m2, conflict;
      logic [LW-1:0] lc;

      assign e  = q_entry_douts[gi];
      assign v  = (CW'(gi) < cnt_reg);
      assign m1 = tag_hit(e.src1_tag, bc_valid, bc_tag);
      assign m2 = tag_hit(e.src2_tag, bc_valid, bc_tag);
      assign lc = LW'(lat_cycles(e.lat));
      // Issuing now would insert at slot lc-1 next cycle, where slot lc shifts.
      assign conflict = e.dst_valid & busy_ext[lc];

      always_comb begin
         woke = e;
         woke.src1_ready = e.src1_ready | m1;
         woke.src2_ready = e.src2_ready | m2;
      end

      assign q_wr_en[gi]   = v & ((~e.src1_ready & m1) | (~e.src2_ready & m2));
      assign q_wr_data[gi] = woke;
      assign cand[gi]      = v & woke.src1_ready & woke.src2_ready & ~conflict;
   end

   // Isolate the lowest set bit: index 0 is the oldest entry.
   assign q_deq_sel_onehot = fu_ready ? (cand & (~cand + N_ENTRIES'(1))) : '0;

   always_comb begin
      enq_merged = ren_entry;
      enq_merged.src1_ready = ren_entry.src1_ready | tag_hit(ren_entry.src1_tag, bc_valid, bc_tag);
      enq_merged.src2_ready = ren_entry.src2_ready | tag_hit(ren_entry.src2_tag, bc_valid, bc_tag);
   end

   assign q_enq_valid = ren_valid;
   assign ren_ready   = q_enq_ready;
   assign q_enq_data  = enq_merged;
   assign q_deq_ready = fu_ready;
   assign iss_valid   = q_deq_valid & fu_ready;
   assign iss_entry   = q_deq_data;

   wake_delay_line #(
      .MAX_LAT   (MAX_LAT),
      .TAG_WIDTH (TAG_WIDTH),
      .LW        (LW)
   ) u_delay (
      .clk        (clk),
      .rst_aL     (rst_aL),
      .ins_valid  (iss_valid & q_deq_data.dst_valid),
      .ins_lat    (LW'(lat_cycles(q_deq_data.lat))),
      .ins_tag    (q_deq_data.dst_tag),
      .head_valid (s0_valid),
      .head_tag   (s0_tag),
      .slot_busy  (slot_busy)
   );

   assign int_wake_valid = s0_valid;
   assign int_wake_tag   = s0_tag;

   always_ff @(posedge clk) begin
      if (!rst_aL) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CW'(q_enq_valid & q_enq_ready) - CW'(iss_valid);
      end
   end

   assign occupancy = cnt_reg;

endmodule

// File: tb/tb_iiq_scheduler.sv
// tb_iiq_scheduler: directed bench for iiq_scheduler. The queue is played by
// the stimulus itself: each step sets the queue contents and handshakes the
// way a shift queue would present them, then checks the scheduler outputs.
module tb_iiq_scheduler;
   import iiq_pkg::*;

   localparam int N  = IIQ_N_ENTRIES;
   localparam int TW = PHYS_TAG_WIDTH;

   logic                   clk = 1'b0;
   logic                   rst_aL;
   logic                   ren_valid;
   logic                   ren_ready;
   iiq_entry_t             ren_entry;
   logic                   q_enq_valid;
   logic                   q_enq_ready;
   iiq_entry_t             q_enq_data;
   logic                   q_deq_ready;
   logic [N-1:0]           q_deq_sel_onehot;
   logic                   q_deq_valid;
   iiq_entry_t             q_deq_data;
   logic [N-1:0]           q_wr_en;
   iiq_entry_t [N-1:0]     q_wr_data;
   iiq_entry_t [N-1:0]     q_entry_douts;
   logic                   fu_ready;
   logic                   iss_valid;
   iiq_entry_t             iss_entry;
   logic [1:0]             ext_wake_valid;
   logic [1:0][TW-1:0]     ext_wake_tag;
   logic                   int_wake_valid;
   logic [TW-1:0]          int_wake_tag;
   logic [$clog2(N):0]     occupancy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iiq_scheduler dut (
      .clk              (clk),
      .rst_aL           (rst_aL),
      .ren_valid        (ren_valid),
      .ren_ready        (ren_ready),
      .ren_entry        (ren_entry),
      .q_enq_valid      (q_enq_valid),
      .q_enq_ready      (q_enq_ready),
      .q_enq_data       (q_enq_data),
      .q_deq_ready      (q_deq_ready),
      .q_deq_sel_onehot (q_deq_sel_onehot),
      .q_deq_valid      (q_deq_valid),
      .q_deq_data       (q_deq_data),
      .q_wr_en          (q_wr_en),
      .q_wr_data        (q_wr_data),
      .q_entry_douts    (q_entry_douts),
      .fu_ready         (fu_ready),
      .iss_valid        (iss_valid),
      .iss_entry        (iss_entry),
      .ext_wake_valid   (ext_wake_valid),
      .ext_wake_tag     (ext_wake_tag),
      .int_wake_valid   (int_wake_valid),
      .int_wake_tag     (int_wake_tag),
      .occupancy        (occupancy)
   );

   function automatic iiq_entry_t mk(input logic r1, input int t1, input logic r2, input int t2,
                                     input logic dv, input int dt, input int lat, input int pl);
      iiq_entry_t e;
      e.src1_ready = r1;        e.src1_tag = TW'(t1);
      e.src2_ready = r2;        e.src2_tag = TW'(t2);
      e.dst_valid  = dv;        e.dst_tag  = TW'(dt);
      e.lat        = 2'(lat);   e.payload  = 8'(pl);
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Next step: wait for the falling edge, clear per-cycle stimulus.
   task automatic step(input string name);
      @(negedge clk);
      $display("step %s", name);
      ren_valid      = 1'b0;
      ren_entry      = '0;
      q_deq_valid    = 1'b0;
      q_deq_data     = '0;
      ext_wake_valid = '0;
      ext_wake_tag   = '0;
      q_enq_ready    = 1'b1;
   endtask

   iiq_entry_t e_rdy, w_wait, w_woke, p_e, d_e, x_e, y_e;
   iiq_entry_t a0, a1, a2, b1, b2, b3, m_e, m_woke;

   initial begin
      e_rdy  = mk(1, 1, 1, 2, 0, 0, 1, 'hA1);
      w_wait = mk(0, 5, 1, 2, 0, 0, 1, 'hB2);
      w_woke = mk(1, 5, 1, 2, 0, 0, 1, 'hB2);
      p_e    = mk(1, 1, 1, 2, 1, 9, 2, 'hC3);
      d_e    = mk(0, 9, 1, 3, 0, 0, 1, 'hD4);
      x_e    = mk(1, 1, 1, 2, 1, 20, 3, 'hE5);
      y_e    = mk(1, 1, 1, 2, 1, 21, 2, 'hF6);
      a0     = mk(1, 1, 1, 2, 0, 0, 1, 'h10);
      a1     = mk(0, 30, 1, 2, 0, 0, 1, 'h11);
      a2     = mk(1, 3, 1, 4, 0, 0, 1, 'h12);
      b1     = mk(1, 1, 1, 2, 0, 0, 1, 'h20);
      b2     = mk(1, 1, 1, 2, 1, 40, 0, 'h21);   // lat code 0 = 4 cycles
      b3     = mk(1, 1, 1, 2, 0, 0, 1, 'h22);
      m_e    = mk(0, 33, 1, 2, 0, 0, 1, 'h23);
      m_woke = mk(1, 33, 1, 2, 0, 0, 1, 'h23);

      rst_aL = 1'b0; fu_ready = 1'b1; q_entry_douts = '0;
      ren_valid = 1'b0; ren_entry = '0; q_deq_valid = 1'b0; q_deq_data = '0;
      ext_wake_valid = '0; ext_wake_tag = '0; q_enq_ready = 1'b1;
      repeat (2) @(posedge clk);

      // Reset state
      step("reset"); #2;
      chk("rst_occ", occupancy, 0);
      chk("rst_sel", q_deq_sel_onehot, 0);
      chk("rst_wr_en", q_wr_en, 0);
      chk("rst_int_wake", int_wake_valid, 0);
      chk("rst_iss", iss_valid, 0);

      // Enqueue into empty queue: not selectable the same cycle
      step("enq_ready"); rst_aL = 1'b1; ren_valid = 1'b1; ren_entry = e_rdy; #2;
      chk("empty_sel", q_deq_sel_onehot, 0);
      chk("ren_ready", ren_ready, 1);
      chk("enq_data_plain", q_enq_data, e_rdy);

      step("issue_ready"); q_entry_douts[0] = e_rdy; q_deq_valid = 1'b1; q_deq_data = e_rdy; #2;
      chk("occ_1", occupancy, 1);
      chk("sel_first", q_deq_sel_onehot, 4'b0001);
      chk("iss_valid", iss_valid, 1);
      chk("iss_entry", iss_entry, e_rdy);

      // Wakeup with bypass
      step("enq_wait"); q_entry_douts = '0; ren_valid = 1'b1; ren_entry = w_wait; #2;
      chk("occ_0", occupancy, 0);
      chk("enq_wait_data", q_enq_data, w_wait);

      step("wait_idle"); q_entry_douts[0] = w_wait; #2;
      chk("wait_sel", q_deq_sel_onehot, 0);
      chk("wait_wr_en", q_wr_en, 0);

      step("ext_wake"); ext_wake_valid = 2'b01; ext_wake_tag[0] = 6'd5;
      q_deq_valid = 1'b1; q_deq_data = w_wait; #2;
      chk("wake_wr_en", q_wr_en, 4'b0001);
      chk("wake_wr_data", q_wr_data[0], w_woke);
      chk("wake_bypass_sel", q_deq_sel_onehot, 4'b0001);

      // Broadcast latency: lat=2 producer, dependent issues at t+2
      step("enq_prod"); q_entry_douts = '0; ren_valid = 1'b1; ren_entry = p_e; #2;
      chk("occ_0b", occupancy, 0);

      step("issue_prod"); q_entry_douts[0] = p_e; ren_valid = 1'b1; ren_entry = d_e;
      q_deq_valid = 1'b1; q_deq_data = p_e; #2;
      chk("prod_sel", q_deq_sel_onehot, 4'b0001);

      step("prod_t1"); q_entry_douts[0] = d_e; #2;
      chk("prod_occ", occupancy, 1);
      chk("t1_int_wake", int_wake_valid, 0);
      chk("dep_sel_t1", q_deq_sel_onehot, 0);

      step("prod_t2"); q_deq_valid = 1'b1; q_deq_data = d_e; #2;
      chk("t2_int_wake", int_wake_valid, 1);
      chk("t2_int_tag", int_wake_tag, 9);
      chk("t2_dep_wr_en", q_wr_en, 4'b0001);
      chk("t2_dep_sel", q_deq_sel_onehot, 4'b0001);

      // Broadcast slot conflict
      step("enq_x"); q_entry_douts = '0; ren_valid = 1'b1; ren_entry = x_e; #2;
      chk("occ_0c", occupancy, 0);

      step("issue_x"); q_entry_douts[0] = x_e; ren_valid = 1'b1; ren_entry = y_e;
      q_deq_valid = 1'b1; q_deq_data = x_e; #2;
      chk("x_sel", q_deq_sel_onehot, 4'b0001);

      step("y_blocked"); q_entry_douts[0] = y_e; #2;
      chk("y_conflict_sel", q_deq_sel_onehot, 0);
      chk("y_occ", occupancy, 1);

      step("y_issue"); q_deq_valid = 1'b1; q_deq_data = y_e; #2;
      chk("y_sel", q_deq_sel_onehot, 4'b0001);
      chk("y_int_wake_early", int_wake_valid, 0);

      step("x_bcast"); q_entry_douts = '0; #2;
      chk("x_int_wake", int_wake_valid, 1);
      chk("x_int_tag", int_wake_tag, 20);

      step("y_bcast"); #2;
      chk("y_int_wake", int_wake_valid, 1);
      chk("y_int_tag", int_wake_tag, 21);

      // Age order, with fu_ready held low while filling
      step("fill_a0"); fu_ready = 1'b0; ren_valid = 1'b1; ren_entry = a0; #2;
      chk("fill_occ0", occupancy, 0);

      step("fill_a1"); q_entry_douts[0] = a0; ren_valid = 1'b1; ren_entry = a1; #2;
      chk("fu_busy_sel", q_deq_sel_onehot, 0);
      chk("fu_busy_deq_ready", q_deq_ready, 0);

      step("fill_a2"); q_entry_douts[1] = a1; ren_valid = 1'b1; ren_entry = a2; #2;
      chk("fill_occ2", occupancy, 2);

      step("age_0"); fu_ready = 1'b1; q_entry_douts[2] = a2; q_deq_valid = 1'b1; q_deq_data = a0; #2;
      chk("age_occ3", occupancy, 3);
      chk("age_sel0", q_deq_sel_onehot, 4'b0001);

      step("age_1"); q_entry_douts = '0; q_entry_douts[0] = a1; q_entry_douts[1] = a2;
      q_deq_valid = 1'b1; q_deq_data = a2; #2;
      chk("age_sel1", q_deq_sel_onehot, 4'b0010);

      // Fill to full, then enq+deq in the same cycle with enqueue merge
      step("fill_b1"); fu_ready = 1'b0; q_entry_douts[1] = '0; ren_valid = 1'b1; ren_entry = b1; #2;
      chk("left_occ1", occupancy, 1);
      chk("left_sel", q_deq_sel_onehot, 0);

      step("fill_b2"); q_entry_douts[1] = b1; ren_valid = 1'b1; ren_entry = b2; #2;
      step("fill_b3"); q_entry_douts[2] = b2; ren_valid = 1'b1; ren_entry = b3; #2;
      chk("fill_occ3", occupancy, 3);

      step("full_enq_deq"); fu_ready = 1'b1; q_entry_douts[3] = b3;
      ren_valid = 1'b1; ren_entry = m_e; ext_wake_valid = 2'b10; ext_wake_tag[1] = 6'd33;
      q_deq_valid = 1'b1; q_deq_data = b1; #2;
      chk("full_occ", occupancy, 4);
      chk("full_sel", q_deq_sel_onehot, 4'b0010);
      chk("full_ren_ready", ren_ready, 1);
      chk("merge_data", q_enq_data, m_woke);
      chk("full_wr_en", q_wr_en, 0);

      step("issue_b2"); q_entry_douts[1] = b2; q_entry_douts[2] = b3; q_entry_douts[3] = m_woke;
      q_deq_valid = 1'b1; q_deq_data = b2; #2;
      chk("full_hold_occ", occupancy, 4);
      chk("b2_sel", q_deq_sel_onehot, 4'b0010);

      // Reset mid-operation drops the pending lat-4 broadcast
      step("reset_mid"); rst_aL = 1'b0; fu_ready = 1'b0; #2;
      chk("pre_rst_occ", occupancy, 3);

      step("post_rst"); rst_aL = 1'b1; fu_ready = 1'b1; q_entry_douts = '0; #2;
      chk("post_rst_occ", occupancy, 0);
      chk("post_rst_sel", q_deq_sel_onehot, 0);

      step("post_rst_1"); #2;
      step("post_rst_2"); #2;
      chk("dropped_bcast", int_wake_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
